// File: rtl/align_link_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : align_link_ctrl_if
//  Description : Aligner-side and payload-side signal bundle for align_link_ctrl.
//  Revision    : 1.0  initial release
// ============================================================================
interface align_link_ctrl_if;
    logic        enable;
    logic        force_retrain;
    logic        align_valid;
    logic [15:0] align_data;
    logic        align_rst;
    logic        link_up;
    logic [15:0] data_out;
    logic        data_valid;
    logic [2:0]  state;
    logic [7:0]  retrain_cnt;

    modport master (
        output enable,
        output force_retrain,
        output align_valid,
        output align_data,
        input  align_rst,
        input  link_up,
        input  data_out,
        input  data_valid,
        input  state,
        input  retrain_cnt
    );

    modport slave (
        input  enable,
        input  force_retrain,
        input  align_valid,
        input  align_data,
        output align_rst,
        output link_up,
        output data_out,
        output data_valid,
        output state,
        output retrain_cnt
    );
endinterface
`default_nettype wire

// File: rtl/align_link_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : align_link_ctrl
//  Description : Link-training sequencer for the 16-lane word aligner.
//  Revision    : 1.0  initial release
// ============================================================================
module align_link_ctrl #(
    parameter logic [15:0] SYNC_PATTERN   = 16'h817E,
    parameter int unsigned RST_CYCLES     = 4,
    parameter int unsigned SEARCH_TIMEOUT = 4096,
    parameter int unsigned GOOD_LIMIT     = 8,
    parameter int unsigned SYNC_WINDOW    = 64,
    parameter int unsigned ERR_LIMIT      = 4
) (
    input  logic             clk,
    input  logic             rst,
    align_link_ctrl_if.slave lnk
);

    localparam logic [2:0] c_st_idle      = 3'd0;
    localparam logic [2:0] c_st_align_rst = 3'd1;
    localparam logic [2:0] c_st_search    = 3'd2;
    localparam logic [2:0] c_st_verify    = 3'd3;
    localparam logic [2:0] c_st_up        = 3'd4;

    localparam logic [15:0] c_rst_last     = 16'(RST_CYCLES - 1);
    localparam logic [15:0] c_timeout_last = 16'(SEARCH_TIMEOUT - 1);
    localparam logic [15:0] c_sync_window  = 16'(SYNC_WINDOW);
    localparam logic [7:0]  c_good_limit   = 8'(GOOD_LIMIT);
    localparam logic [7:0]  c_err_limit    = 8'(ERR_LIMIT);

    logic [2:0]  r_state;
    logic [15:0] r_timer;
    logic [7:0]  r_good_cnt;
    logic [15:0] r_win_cnt;
    logic [7:0]  r_err_cnt;
    logic [7:0]  r_retrain_cnt;
    logic        r_align_rst;
    logic        r_link_up;
    logic        r_data_valid;
    logic [15:0] r_data_out;

    logic [2:0]  w_state_nxt;
    logic [15:0] w_timer_nxt;
    logic [7:0]  w_good_nxt;
    logic [15:0] w_win_nxt;
    logic [7:0]  w_err_nxt;
    logic        w_retrain;
    logic        w_is_sync;
    logic        w_payload;
    logic [15:0] w_timer_inc;
    logic [15:0] w_win_inc;
    logic [7:0]  w_good_inc;
    logic [7:0]  w_err_inc;

    assign w_is_sync   = (lnk.align_data == SYNC_PATTERN);
    assign w_timer_inc = r_timer + 16'd1;
    assign w_win_inc   = r_win_cnt + 16'd1;
    assign w_good_inc  = r_good_cnt + 8'd1;
    assign w_err_inc   = r_err_cnt + 8'd1;
    assign w_payload   = (r_state == c_st_up) && lnk.align_valid && !w_is_sync;

    always_comb begin
        w_state_nxt = r_state;
        w_timer_nxt = r_timer;
        w_good_nxt  = r_good_cnt;
        w_win_nxt   = r_win_cnt;
        w_err_nxt   = r_err_cnt;
        w_retrain   = 1'b0;

        if (!lnk.enable) begin
            w_state_nxt = c_st_idle;
            w_timer_nxt = 16'd0;
            w_good_nxt  = 8'd0;
            w_win_nxt   = 16'd0;
            w_err_nxt   = 8'd0;
        end else if (lnk.force_retrain && (r_state != c_st_idle)) begin
            w_retrain = 1'b1;
        end else begin
            case (r_state)
                c_st_idle: begin
                    w_state_nxt = c_st_align_rst;
                    w_timer_nxt = 16'd0;
                end
                c_st_align_rst: begin
                    if (r_timer == c_rst_last) begin
                        w_state_nxt = c_st_search;
                        w_timer_nxt = 16'd0;
                    end else begin
                        w_timer_nxt = w_timer_inc;
                    end
                end
                c_st_search: begin
                    if (lnk.align_valid) begin
                        w_state_nxt = c_st_verify;
                        w_timer_nxt = 16'd0;
                        w_good_nxt  = 8'd0;
                        w_win_nxt   = 16'd0;
                    end else if (r_timer == c_timeout_last) begin
                        w_retrain = 1'b1;
                    end else begin
                        w_timer_nxt = w_timer_inc;
                    end
                end
                c_st_verify: begin
                    if (lnk.align_valid) begin
                        if (w_is_sync) begin
                            w_win_nxt  = 16'd0;
                            w_good_nxt = w_good_inc;
                            if (w_good_inc == c_good_limit) begin
                                w_state_nxt = c_st_up;
                                w_good_nxt  = 8'd0;
                                w_err_nxt   = 8'd0;
                                w_timer_nxt = 16'd0;
                            end
                        end else if (w_win_inc == c_sync_window) begin
                            w_retrain = 1'b1;
                        end else begin
                            w_win_nxt = w_win_inc;
                        end
                    end
                end
                c_st_up: begin
                    if (lnk.align_valid) begin
                        w_timer_nxt = 16'd0;
                        if (w_is_sync) begin
                            w_win_nxt = 16'd0;
                            w_err_nxt = 8'd0;
                        end else if (w_win_inc == c_sync_window) begin
                            // A full window without sync is one miss; enough in a row retrains.
                            w_win_nxt = 16'd0;
                            w_err_nxt = w_err_inc;
                            if (w_err_inc == c_err_limit) begin
                                w_retrain = 1'b1;
                            end
                        end else begin
                            w_win_nxt = w_win_inc;
                        end
                    end else if (r_timer == c_timeout_last) begin
                        w_retrain = 1'b1;
                    end else begin
                        w_timer_nxt = w_timer_inc;
                    end
                end
                default: begin
                    w_state_nxt = c_st_idle;
                    w_timer_nxt = 16'd0;
                    w_good_nxt  = 8'd0;
                    w_win_nxt   = 16'd0;
                    w_err_nxt   = 8'd0;
                end
            endcase
        end

        if (w_retrain) begin
            w_state_nxt = c_st_align_rst;
            w_timer_nxt = 16'd0;
            w_good_nxt  = 8'd0;
            w_win_nxt   = 16'd0;
            w_err_nxt   = 8'd0;
        end
    end

    // Status outputs are decoded from the next state so they register alongside it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= c_st_idle;
            r_timer       <= 16'd0;
            r_good_cnt    <= 8'd0;
            r_win_cnt     <= 16'd0;
            r_err_cnt     <= 8'd0;
            r_retrain_cnt <= 8'd0;
            r_align_rst   <= 1'b1;
            r_link_up     <= 1'b0;
            r_data_valid  <= 1'b0;
            r_data_out    <= 16'd0;
        end else begin
            r_state      <= w_state_nxt;
            r_timer      <= w_timer_nxt;
            r_good_cnt   <= w_good_nxt;
            r_win_cnt    <= w_win_nxt;
            r_err_cnt    <= w_err_nxt;
            r_align_rst  <= (w_state_nxt == c_st_idle) || (w_state_nxt == c_st_align_rst);
            r_link_up    <= (w_state_nxt == c_st_up);
            r_data_valid <= w_payload;
            if (w_payload) begin
                r_data_out <= lnk.align_data;
            end
            if (w_retrain && (r_retrain_cnt != 8'hFF)) begin
                r_retrain_cnt <= r_retrain_cnt + 8'd1;
            end
        end
    end

    assign lnk.align_rst   = r_align_rst;
    assign lnk.link_up     = r_link_up;
    assign lnk.data_out    = r_data_out;
    assign lnk.data_valid  = r_data_valid;
    assign lnk.state       = r_state;
    assign lnk.retrain_cnt = r_retrain_cnt;

endmodule
`default_nettype wire

// File: tb/tb_align_link_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_align_link_ctrl
//  Description : Directed bench for align_link_ctrl with a payload scoreboard.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_align_link_ctrl;

    localparam logic [15:0] c_sync = 16'h817E;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;
    int   n_dv;
    logic m_up;
    logic [15:0] q_exp[$];

    align_link_ctrl_if dut_if ();

    align_link_ctrl u_dut (
        .clk (clk),
        .rst (rst),
        .lnk (dut_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, wait for the opposite edge, then score any payload word.
    task automatic cyc(input logic en, input logic fr, input logic v, input logic [15:0] d);
        dut_if.enable        = en;
        dut_if.force_retrain = fr;
        dut_if.align_valid   = v;
        dut_if.align_data    = d;
        @(negedge clk);
        if (!rst && dut_if.data_valid === 1'b1) begin
            n_dv++;
            chk("sb_word_expected", 32'(q_exp.size() > 0), 32'd1);
            if (q_exp.size() > 0) chk("data_out", dut_if.data_out, q_exp.pop_front());
        end
    endtask

    task automatic send(input logic [15:0] d);
        if (m_up && d != c_sync) q_exp.push_back(d);
        cyc(1'b1, 1'b0, 1'b1, d);
    endtask

    task automatic bring_up();
        int n;
        logic [15:0] w;
        n = 0;
        while (dut_if.state !== 3'd2 && n < 40) begin
            cyc(1'b1, 1'b0, 1'b0, 16'h0);
            n++;
        end
        chk("search_entry", dut_if.state, 3'd2);
        chk("search_align_rst", dut_if.align_rst, 1'b0);
        repeat (10) cyc(1'b1, 1'b0, 1'b0, 16'h0);
        chk("search_hold", dut_if.state, 3'd2);
        for (int k = 0; k < 128; k++) begin
            w = (k % 16 == 15) ? c_sync : 16'(16'h0200 + k);
            send(w);
            if (k == 126) chk("pre_up_link", dut_if.link_up, 1'b0);
        end
        chk("link_up", dut_if.link_up, 1'b1);
        chk("state_up", dut_if.state, 3'd4);
        m_up = 1'b1;
    endtask

    initial begin
        int n;
        int dv_base;
        n_cmp = 0;
        n_err = 0;
        n_dv  = 0;
        m_up  = 1'b0;
        rst   = 1'b1;
        dut_if.enable        = 1'b0;
        dut_if.force_retrain = 1'b0;
        dut_if.align_valid   = 1'b0;
        dut_if.align_data    = 16'h0;
        repeat (3) @(negedge clk);
        chk("rst_state", dut_if.state, 3'd0);
        chk("rst_align_rst", dut_if.align_rst, 1'b1);
        chk("rst_link_up", dut_if.link_up, 1'b0);
        chk("rst_data_valid", dut_if.data_valid, 1'b0);
        chk("rst_data_out", dut_if.data_out, 16'h0);
        chk("rst_retrain", dut_if.retrain_cnt, 8'h0);
        rst = 1'b0;

        // Training from IDLE: reset pulse length, then lock-up
        cyc(1'b1, 1'b0, 1'b0, 16'h0);
        n = 0;
        while (dut_if.state === 3'd1 && n < 20) begin
            chk("arst_level", dut_if.align_rst, 1'b1);
            n++;
            cyc(1'b1, 1'b0, 1'b0, 16'h0);
        end
        chk("arst_len", n, 4);
        bring_up();
        chk("t1_retrain", dut_if.retrain_cnt, 8'd0);

        // Search timeout
        cyc(1'b0, 1'b0, 1'b0, 16'h0);
        m_up = 1'b0;
        chk("disable_idle", dut_if.state, 3'd0);
        cyc(1'b1, 1'b0, 1'b0, 16'h0);
        while (dut_if.state === 3'd1) cyc(1'b1, 1'b0, 1'b0, 16'h0);
        n = 0;
        while (dut_if.state === 3'd2 && n < 5000) begin
            n++;
            cyc(1'b1, 1'b0, 1'b0, 16'h0);
        end
        chk("search_len", n, 4096);
        chk("timeout_state", dut_if.state, 3'd1);
        chk("timeout_retrain", dut_if.retrain_cnt, 8'd1);
        n = 0;
        while (dut_if.state === 3'd1 && n < 20) begin
            chk("retrain_arst_level", dut_if.align_rst, 1'b1);
            n++;
            cyc(1'b1, 1'b0, 1'b0, 16'h0);
        end
        chk("retrain_arst_len", n, 4);

        // Four consecutive misses in UP
        bring_up();
        dv_base = n_dv;
        for (int k = 0; k < 256; k++) begin
            send(16'(16'h0400 + k));
            if (k == 191 || k == 254) chk("miss_link_hold", dut_if.link_up, 1'b1);
        end
        m_up = 1'b0;
        chk("miss_link_drop", dut_if.link_up, 1'b0);
        chk("miss_state", dut_if.state, 3'd1);
        chk("miss_retrain", dut_if.retrain_cnt, 8'd2);
        chk("miss_dv_count", n_dv - dv_base, 256);
        chk("miss_sb_empty", q_exp.size(), 0);

        // Sync clears misses; a sync on the window boundary is not a miss; lock loss
        bring_up();
        for (int k = 0; k < 192; k++) send(16'(16'h0600 + k));
        send(c_sync);
        for (int k = 0; k < 192; k++) send(16'(16'h0700 + k));
        chk("err_clear_link", dut_if.link_up, 1'b1);
        for (int k = 0; k < 63; k++) send(16'(16'h0800 + k));
        send(c_sync);
        chk("window_edge_sync", dut_if.link_up, 1'b1);
        chk("window_edge_state", dut_if.state, 3'd4);
        repeat (4095) cyc(1'b1, 1'b0, 1'b0, 16'h0);
        chk("lock_loss_hold", dut_if.link_up, 1'b1);
        cyc(1'b1, 1'b0, 1'b0, 16'h0);
        m_up = 1'b0;
        chk("lock_loss_drop", dut_if.link_up, 1'b0);
        chk("lock_loss_retrain", dut_if.retrain_cnt, 8'd3);

        // enable=0 beats force_retrain; force in IDLE does not count
        bring_up();
        q_exp.push_back(16'h0A5A);
        cyc(1'b0, 1'b1, 1'b1, 16'h0A5A);
        m_up = 1'b0;
        chk("prio_state", dut_if.state, 3'd0);
        chk("prio_link", dut_if.link_up, 1'b0);
        chk("prio_align_rst", dut_if.align_rst, 1'b1);
        chk("prio_retrain", dut_if.retrain_cnt, 8'd3);
        cyc(1'b1, 1'b1, 1'b0, 16'h0);
        chk("idle_force_state", dut_if.state, 3'd1);
        chk("idle_force_retrain", dut_if.retrain_cnt, 8'd3);
        chk("prio_sb_empty", q_exp.size(), 0);

        // Saturation, then async reset during VERIFY
        repeat (251) cyc(1'b1, 1'b1, 1'b0, 16'h0);
        chk("sat_pre", dut_if.retrain_cnt, 8'hFE);
        repeat (49) cyc(1'b1, 1'b1, 1'b0, 16'h0);
        chk("sat_value", dut_if.retrain_cnt, 8'hFF);
        chk("sat_state", dut_if.state, 3'd1);
        n = 0;
        while (dut_if.state !== 3'd2 && n < 20) begin
            cyc(1'b1, 1'b0, 1'b0, 16'h0);
            n++;
        end
        send(16'h0123);
        send(c_sync);
        send(c_sync);
        chk("verify_state", dut_if.state, 3'd3);
        rst = 1'b1;
        #1;
        chk("arst_state", dut_if.state, 3'd0);
        chk("arst_align_rst", dut_if.align_rst, 1'b1);
        chk("arst_link_up", dut_if.link_up, 1'b0);
        chk("arst_data_valid", dut_if.data_valid, 1'b0);
        chk("arst_data_out", dut_if.data_out, 16'h0);
        chk("arst_retrain", dut_if.retrain_cnt, 8'h0);
        chk("final_sb_empty", q_exp.size(), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
